// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential signed divider.
package seq_divider_pkg;

  localparam int unsigned DEFAULT_DIVIDEND_W = 16;
  localparam int unsigned DEFAULT_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Sequential signed divider: one restoring radix-2 step per cycle on operand
// magnitudes, followed by a single sign fix-up cycle. Quotient truncates toward
// zero and the remainder carries the dividend's sign.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEFAULT_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEFAULT_DIVISOR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         busy,
  output logic                         done,
  output logic signed [DIVIDEND_W-1:0] quotient,
  output logic signed [DIVISOR_W-1:0]  remainder,
  output logic                         div_by_zero,
  output logic                         overflow
);

  localparam int unsigned MAG_W = DIVIDEND_W + 1;
  localparam int unsigned REM_W = DIVISOR_W + 1;
  localparam int unsigned TRY_W = DIVISOR_W + 2;
  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  // Dividend magnitude bits shift out of the top while quotient bits shift in.
  logic [MAG_W-1:0] q_mag;
  logic [REM_W-1:0] part_rem;
  logic [REM_W-1:0] dvs_mag;
  logic             dvd_neg;
  logic             dvs_neg;

  logic [MAG_W-1:0] dvd_ext;
  logic [MAG_W-1:0] dvd_abs;
  logic [REM_W-1:0] dvs_ext;
  logic [REM_W-1:0] dvs_abs;

  logic [TRY_W-1:0] shifted;
  logic [TRY_W-1:0] trial;
  logic             q_bit;
  logic [REM_W-1:0] next_rem;

  logic [MAG_W-1:0]     q_signed;
  logic [DIVISOR_W-1:0] r_signed;
  logic                 q_out_of_range;

  // Operand magnitudes, widened by one bit so the most-negative value is exact.
  always_comb begin
    dvd_ext = {dividend[DIVIDEND_W-1], dividend};
    dvd_abs = dividend[DIVIDEND_W-1] ? MAG_W'(-dvd_ext) : dvd_ext;
    dvs_ext = {divisor[DIVISOR_W-1], divisor};
    dvs_abs = divisor[DIVISOR_W-1] ? REM_W'(-dvs_ext) : dvs_ext;
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted  = {part_rem, q_mag[DIVIDEND_W-1]};
    trial    = shifted - {1'b0, dvs_mag};
    q_bit    = ~trial[TRY_W-1];
    next_rem = q_bit ? trial[REM_W-1:0] : shifted[REM_W-1:0];
  end

  // Sign fix-up; a positive quotient magnitude that does not fit is the overflow case.
  always_comb begin
    q_signed       = (dvd_neg ^ dvs_neg) ? MAG_W'(-q_mag) : q_mag;
    r_signed       = dvd_neg ? DIVISOR_W'(-part_rem[DIVISOR_W-1:0])
                             : part_rem[DIVISOR_W-1:0];
    q_out_of_range = q_signed[MAG_W-1] ^ q_signed[DIVIDEND_W-1];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      q_mag       <= '0;
      part_rem    <= '0;
      dvs_mag     <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_neg  <= dividend[DIVIDEND_W-1];
            dvs_neg  <= divisor[DIVISOR_W-1];
            q_mag    <= dvd_abs;
            dvs_mag  <= dvs_abs;
            part_rem <= '0;
            count    <= CNT_W'(DIVIDEND_W);
            overflow <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          part_rem <= next_rem;
          q_mag    <= {1'b0, q_mag[DIVIDEND_W-2:0], q_bit};
          count    <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          quotient  <= q_signed[DIVIDEND_W-1:0];
          remainder <= r_signed;
          overflow  <= q_out_of_range;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 16, meaning dividend and quotient width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 8, meaning divisor and remainder width in bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-006 SHALL have port dividend, input signed, DIVIDEND_W, numerator; captured when start is accepted.
REQ-007 SHALL have port divisor, input signed, DIVISOR_W, denominator; captured when start is accepted.
REQ-008 SHALL have port busy, output, 1, high from the cycle after acceptance until done.
REQ-009 SHALL have port done, output, 1, one-cycle pulse; results valid.
REQ-010 SHALL have port quotient, output signed, DIVIDEND_W, result truncated toward zero.
REQ-011 SHALL have port remainder, output signed, DIVISOR_W, remainder; sign equals dividend sign, or zero.
REQ-012 SHALL have port div_by_zero, output, 1, status flag for the last operation.
REQ-013 SHALL have port overflow, output, 1, status flag for the last operation.

Function
REQ-014 SHALL implement the states IDLE, CALC, FIXUP and DONE.
REQ-015 SHALL accept start in IDLE only; acceptance captures the operands and the operand signs, and takes absolute values at DIVIDEND_W+1 bits.
REQ-016 SHALL move from IDLE to CALC on acceptance with a nonzero divisor, and load the iteration counter with DIVIDEND_W.
REQ-017 SHALL perform in CALC one restoring radix-2 step per cycle: shift the partial remainder left, subtract |divisor|, set the quotient bit, and decrement the counter; CALC lasts exactly DIVIDEND_W cycles.
REQ-018 SHALL in FIXUP, in one cycle, negate the quotient if the operand signs differ and negate the remainder if the dividend is negative.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL produce done in the (DIVIDEND_W+2)th cycle after the accepting edge; this is 18 cycles for the default widths.
REQ-021 SHALL, for a zero divisor, go from IDLE directly to DONE with quotient=0, remainder=0 and div_by_zero=1; done appears 1 cycle after acceptance.
REQ-022 SHALL, for dividend = most-negative and divisor = -1, produce quotient = most-negative (0x8000), remainder=0 and overflow=1.
REQ-023 SHALL hold quotient, remainder, div_by_zero and overflow stable from done until the next done.
REQ-024 SHALL clear div_by_zero and overflow on every acceptance.
REQ-025 SHALL ignore start while busy; operands that change while busy SHALL NOT affect the result.
REQ-026 SHALL accept a start asserted in the same cycle as done only on the following cycle, once in IDLE.
REQ-027 SHALL size all internal arithmetic to avoid intermediate truncation: partial remainder DIVISOR_W+1 bits, magnitudes DIVIDEND_W+1 bits.

Reset
REQ-028 SHALL, while reset is high, force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and overflow=0, independent of clk.
REQ-029 SHALL abandon an operation interrupted by reset with no done pulse; the first accepted start after reset SHALL behave as from power-up.

Structure
REQ-030 SHALL define the state enumeration and the default width constants in shared package seq_divider_pkg.
REQ-031 SHALL be a single module with no sub-modules; the iteration step and sign fix-up are inline.

Verification
REQ-032 SHALL cover: 100 / 7 -> done at cycle 18, quotient=14, remainder=2, flags 0.
REQ-033 SHALL cover: -100 / 7 -> quotient=0xFFF2 (-14), remainder=0xFE (-2); and 100 / -7 -> quotient=-14, remainder=2.
REQ-034 SHALL cover: 1234 / 0 -> done 1 cycle after acceptance, div_by_zero=1, quotient=0, remainder=0.
REQ-035 SHALL cover: -32768 / -1 -> overflow=1, quotient=0x8000, remainder=0; then 32767 / -128 -> quotient=-255, remainder=127, overflow=0.
REQ-036 SHALL cover: start pulsed with new operands at cycle 5 of a busy 100/7 operation -> result is still 14 r 2 and only one done pulse occurs.
REQ-037 SHALL cover: reset asserted at cycle 9 of an operation -> all outputs go to 0 immediately with no done; then 50 / 5 -> quotient=10, remainder=0.
